// File: rtl/can_apb_master_pkg.sv
// Shared types and constants for the CAN-side APB initiator.
package can_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_t;

    // Registers are word-spaced in the CAN window.
    localparam int         REG_ADDR_LSB = 2;
    localparam logic [3:0] PSTRB_BYTE0  = 4'b0001;

    // Payload returned on the response channel.
    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
        logic       timeout;
    } apb_rsp_t;

    // Byte offset of register idx inside the CAN window.
    function automatic logic [31:0] reg_offset(input logic [7:0] idx);
        return 32'(idx) << REG_ADDR_LSB;
    endfunction

endpackage

// File: rtl/can_apb_master_if.sv
// APB3/APB4 bus between the initiator and the CAN controller register port.
interface can_apb_master_if;

    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/can_apb_master.sv
// Single-outstanding APB initiator: byte-wide register commands in,
// one APB transfer each, response (rdata / err / timeout) out.
module can_apb_master
    import can_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [2:0]  PPROT_VAL      = 3'b000
) (
    input  logic       aclk,
    input  logic       arstn,

    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_write_i,
    input  logic [7:0] cmd_reg_i,
    input  logic [7:0] cmd_wdata_i,

    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_err_o,
    output logic       rsp_timeout_o,

    output logic       busy_o,

    can_apb_master_if.master m_apb
);

    // Counter just wide enough to reach TIMEOUT_CYCLES; a 1-bit stub when disabled.
    localparam int             CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    apb_mst_state_t   state;
    logic [CNT_W-1:0] wait_cnt;
    apb_rsp_t         rsp;
    logic             rsp_valid;
    logic             busy;

    logic [31:0]      paddr;
    logic             psel;
    logic             penable;
    logic             pwrite;
    logic [31:0]      pwdata;
    logic [3:0]       pstrb;

    // Only the low byte of read data carries a CAN register value.
    logic             prdata_hi_unused;
    assign prdata_hi_unused = ^m_apb.prdata[31:8];

    // Transfer sequencer: accept, SETUP, ACCESS with wait/timeout, hold response.
    always_ff @(posedge aclk) begin
        if (!arstn) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            rsp       <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            paddr     <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        paddr   <= BASE_ADDR + reg_offset(cmd_reg_i);
                        pwrite  <= cmd_write_i;
                        pwdata  <= {24'h0, cmd_wdata_i};
                        pstrb   <= cmd_write_i ? PSTRB_BYTE0 : 4'b0000;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SETUP;
                    end
                end

                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end

                ACCESS: begin
                    if (m_apb.pready) begin
                        // A ready slave always beats a coincident timeout.
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp.rdata   <= pwrite ? 8'h00 : m_apb.prdata[7:0];
                        rsp.err     <= m_apb.pslverr;
                        rsp.timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        if (wait_cnt != CNT_MAX) begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                        if (TIMEOUT_EN && (wait_cnt == CNT_LAST)) begin
                            psel        <= 1'b0;
                            penable     <= 1'b0;
                            rsp.rdata   <= 8'h00;
                            rsp.err     <= 1'b1;
                            rsp.timeout <= 1'b1;
                            rsp_valid   <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o   = (state == IDLE);
    assign busy_o        = busy;
    assign rsp_valid_o   = rsp_valid;
    assign rsp_rdata_o   = rsp.rdata;
    assign rsp_err_o     = rsp.err;
    assign rsp_timeout_o = rsp.timeout;

    assign m_apb.paddr   = paddr;
    assign m_apb.psel    = psel;
    assign m_apb.penable = penable;
    assign m_apb.pwrite  = pwrite;
    assign m_apb.pwdata  = pwdata;
    assign m_apb.pstrb   = pstrb;
    assign m_apb.pprot   = PPROT_VAL;

endmodule

// File: tb/tb_can_apb_master.sv
// Directed and randomized transfers against can_apb_master with a
// bench-side APB slave and an expected-response model.
module tb_can_apb_master;
    import can_apb_pkg::*;

    localparam logic [31:0] BASE    = 32'h4000_0000;
    localparam int          TO_CYC  = 16;
    localparam logic [2:0]  PROT    = 3'b010;

    logic       aclk;
    logic       arstn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       busy;

    int errors = 0;
    int checks = 0;

    can_apb_master_if apb_if ();

    can_apb_master #(
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TO_CYC),
        .PPROT_VAL      (PROT)
    ) dut (
        .aclk          (aclk),
        .arstn         (arstn),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_write_i   (cmd_write),
        .cmd_reg_i     (cmd_reg),
        .cmd_wdata_i   (cmd_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_timeout),
        .busy_o        (busy),
        .m_apb         (apb_if)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete command. waits >= TO_CYC means the slave never answers.
    task automatic do_txn(input bit wr, input logic [7:0] rg, input logic [7:0] wd,
                          input int waits, input logic [31:0] prd, input bit slv,
                          input int hold, input bit busy_cmd);
        logic [31:0] exp_addr;
        logic [7:0]  exp_rdata;
        bit          exp_err;
        bit          exp_to;
        exp_addr = BASE + (32'(rg) * 4);
        if (waits >= TO_CYC) begin
            exp_rdata = 8'h00; exp_err = 1'b1; exp_to = 1'b1;
        end else begin
            exp_rdata = wr ? 8'h00 : prd[7:0]; exp_err = slv; exp_to = 1'b0;
        end

        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_reg = rg; cmd_wdata = wd;
        @(negedge aclk);
        // Scramble command inputs: they must not be sampled while busy.
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_reg = 8'($urandom); cmd_wdata = 8'($urandom);

        check("setup_psel",    32'(apb_if.psel),    32'd1);
        check("setup_penable", 32'(apb_if.penable), 32'd0);
        check("setup_paddr",   apb_if.paddr,        exp_addr);
        check("setup_pwrite",  32'(apb_if.pwrite),  32'(wr));
        check("setup_pwdata",  apb_if.pwdata,       {24'h0, wd});
        check("setup_pstrb",   32'(apb_if.pstrb),   wr ? 32'd1 : 32'd0);
        check("setup_busy",    32'(busy),           32'd1);
        check("setup_cmd_rdy", 32'(cmd_ready),      32'd0);
        @(negedge aclk);

        for (int a = 0; a < TO_CYC; a++) begin
            check("acc_psel",    32'(apb_if.psel),    32'd1);
            check("acc_penable", 32'(apb_if.penable), 32'd1);
            check("acc_paddr",   apb_if.paddr,        exp_addr);
            check("acc_pstrb",   32'(apb_if.pstrb),   wr ? 32'd1 : 32'd0);
            check("acc_rsp_vld", 32'(rsp_valid),      32'd0);
            if (a == waits) begin
                apb_if.pready = 1'b1; apb_if.prdata = prd; apb_if.pslverr = slv;
            end else begin
                apb_if.pready = 1'b0; apb_if.prdata = $urandom; apb_if.pslverr = 1'($urandom);
            end
            @(negedge aclk);
            apb_if.pready = 1'b0;
            if (a == waits || a == TO_CYC - 1) break;
        end

        check("rsp_psel",    32'(apb_if.psel),    32'd0);
        check("rsp_penable", 32'(apb_if.penable), 32'd0);
        check("rsp_valid",   32'(rsp_valid),      32'd1);
        check("rsp_rdata",   32'(rsp_rdata),      32'(exp_rdata));
        check("rsp_err",     32'(rsp_err),        32'(exp_err));
        check("rsp_timeout", 32'(rsp_timeout),    32'(exp_to));
        check("rsp_busy",    32'(busy),           32'd1);

        for (int h = 0; h < hold; h++) begin
            cmd_valid = busy_cmd; cmd_write = 1'($urandom); cmd_reg = 8'($urandom);
            rsp_ready = 1'b0;
            @(negedge aclk);
            check("hold_valid",   32'(rsp_valid),   32'd1);
            check("hold_rdata",   32'(rsp_rdata),   32'(exp_rdata));
            check("hold_err",     32'(rsp_err),     32'(exp_err));
            check("hold_timeout", 32'(rsp_timeout), 32'(exp_to));
            check("hold_cmd_rdy", 32'(cmd_ready),   32'd0);
            check("hold_psel",    32'(apb_if.psel), 32'd0);
        end

        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        check("done_rsp_vld", 32'(rsp_valid),    32'd0);
        check("done_busy",    32'(busy),         32'd0);
        check("done_psel",    32'(apb_if.psel),  32'd0);
        check("done_paddr",   apb_if.paddr,      exp_addr);
    endtask

    initial begin
        arstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_reg = 8'h00; cmd_wdata = 8'h00;
        rsp_ready = 1'b0;
        apb_if.pready = 1'b0; apb_if.prdata = 32'h0; apb_if.pslverr = 1'b0;
        @(negedge aclk);
        @(negedge aclk);

        check("rst_psel",      32'(apb_if.psel),    32'd0);
        check("rst_penable",   32'(apb_if.penable), 32'd0);
        check("rst_pwrite",    32'(apb_if.pwrite),  32'd0);
        check("rst_paddr",     apb_if.paddr,        32'd0);
        check("rst_pwdata",    apb_if.pwdata,       32'd0);
        check("rst_pstrb",     32'(apb_if.pstrb),   32'd0);
        check("rst_rsp_valid", 32'(rsp_valid),      32'd0);
        check("rst_rsp_err",   32'(rsp_err),        32'd0);
        check("rst_rsp_to",    32'(rsp_timeout),    32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata),      32'd0);
        check("rst_busy",      32'(busy),           32'd0);
        check("rst_cmd_ready", 32'(cmd_ready),      32'd1);
        check("pprot",         32'(apb_if.pprot),   32'(PROT));
        arstn = 1'b1;
        @(negedge aclk);

        // Zero-wait write.
        do_txn(1'b1, 8'h04, 8'hA5, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        // Read with three wait states; upper prdata bits are ignored.
        do_txn(1'b0, 8'h02, 8'h00, 3, 32'hFFFF_FF3C, 1'b0, 0, 1'b0);
        // Slave error on the ready cycle.
        do_txn(1'b0, 8'h11, 8'h00, 1, 32'h0000_0077, 1'b1, 0, 1'b0);
        // Slave never answers: timeout after TO_CYC ACCESS cycles.
        do_txn(1'b0, 8'h20, 8'h00, 100, 32'h0000_0055, 1'b0, 0, 1'b0);
        // Ready on the last allowed cycle wins over the timeout.
        do_txn(1'b0, 8'h21, 8'h00, TO_CYC - 1, 32'h0000_0099, 1'b0, 0, 1'b0);
        // Stalled response with a command waiting; next command right after.
        do_txn(1'b1, 8'h30, 8'h5A, 2, 32'h0, 1'b0, 5, 1'b1);
        do_txn(1'b0, 8'hFF, 8'h00, 0, 32'h1234_56C3, 1'b0, 0, 1'b0);

        // Reset while in ACCESS.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_reg = 8'h07;
        @(negedge aclk);
        cmd_valid = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        check("pre_rst_psel", 32'(apb_if.psel), 32'd1);
        arstn = 1'b0;
        @(negedge aclk);
        arstn = 1'b1;
        check("midrst_psel",    32'(apb_if.psel),    32'd0);
        check("midrst_penable", 32'(apb_if.penable), 32'd0);
        check("midrst_rsp_vld", 32'(rsp_valid),      32'd0);
        check("midrst_busy",    32'(busy),           32'd0);
        @(negedge aclk);
        check("postrst_rsp_vld", 32'(rsp_valid), 32'd0);
        do_txn(1'b0, 8'h07, 8'h00, 1, 32'h0000_00E1, 1'b0, 1, 1'b0);

        // Randomized transfers.
        for (int n = 0; n < 24; n++) begin
            bit          wr;
            logic [7:0]  rg;
            logic [7:0]  wd;
            int          waits;
            logic [31:0] prd;
            bit          slv;
            int          hold;
            bit          bc;
            wr    = 1'($urandom);
            rg    = 8'($urandom);
            wd    = 8'($urandom);
            waits = ($urandom_range(0, 6) == 0) ? TO_CYC + int'($urandom_range(0, 4))
                                                 : int'($urandom_range(0, 4));
            prd   = $urandom;
            slv   = ($urandom_range(0, 3) == 0);
            hold  = int'($urandom_range(0, 3));
            bc    = 1'($urandom);
            do_txn(wr, rg, wd, waits, prd, slv, hold, bc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
